// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and helpers for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        BYTES = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4
    } state_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Packs a byte stream little-endian into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          insert_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_next_o,
    output logic                          word_full_o
);

    logic [1:0]                   byte_idx_q;
    logic [8*BYTES_PER_WORD-1:0]  word_q;
    logic [8*BYTES_PER_WORD-1:0]  word_d;

    // word_d is the word as it will look once the current byte lands, so the
    // owner can capture a complete word on the same edge as its last byte.
    always_comb begin
        word_d                     = word_q;
        word_d[8*byte_idx_q +: 8]  = byte_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
        end else if (clear_i) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
        end else if (insert_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            word_q     <= word_d;
        end
    end

    assign word_next_o = word_d;
    assign word_full_o = insert_i && (byte_idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Loads a checksummed byte-stream program image into imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned     c_DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] c_ONE      = 1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;

    state_e              state_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                cpu_run_q;
    logic                load_done_q;
    logic                load_err_q;
    logic [ADDR_W:0]     n_q;
    logic [7:0]          csum_q;

    logic                        w_hs;
    logic                        w_cnt_bad;
    logic                        w_last;
    logic                        w_clear;
    logic                        w_insert;
    logic                        w_word_full;
    logic [8*BYTES_PER_WORD-1:0] w_word_next;

    assign w_hs      = in_valid && in_ready_q;
    assign w_cnt_bad = (in_data == 8'd0) || ({24'd0, in_data} > c_DEPTH);
    assign w_last    = ({1'b0, addr_q} == (n_q - c_ONE));
    assign w_clear   = (state_q == COUNT) && w_hs;
    assign w_insert  = (state_q == BYTES) && w_hs;

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (w_clear),
        .insert_i    (w_insert),
        .byte_i      (in_data),
        .word_next_o (w_word_next),
        .word_full_o (w_word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            n_q         <= '0;
            csum_q      <= 8'd0;
        end else begin
            imem_we_q   <= 1'b0;
            load_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= COUNT;
                        cpu_run_q  <= 1'b0;
                        load_err_q <= 1'b0;
                        csum_q     <= 8'd0;
                        in_ready_q <= 1'b1;
                    end
                end
                COUNT: begin
                    if (w_hs) begin
                        csum_q <= csum_q ^ in_data;
                        if (w_cnt_bad) begin
                            load_err_q <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            n_q     <= in_data[ADDR_W:0];
                            addr_q  <= '0;
                            state_q <= BYTES;
                        end
                    end
                end
                BYTES: begin
                    if (w_hs) begin
                        csum_q <= csum_q ^ in_data;
                        // Last byte of a word: capture it and stall the stream for the write.
                        if (w_word_full) begin
                            in_ready_q <= 1'b0;
                            imem_we_q  <= 1'b1;
                            wdata_q    <= w_word_next;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    in_ready_q <= 1'b1;
                    if (w_last) begin
                        state_q <= CSUM;
                    end else begin
                        addr_q  <= addr_q + c_ADDR_ONE;
                        state_q <= BYTES;
                    end
                end
                CSUM: begin
                    if (w_hs) begin
                        in_ready_q <= 1'b0;
                        state_q    <= IDLE;
                        if (in_data == csum_q) begin
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                        end else begin
                            load_err_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_run    = cpu_run_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomized self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observed memory writes and completion pulses
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
                check("ready_low_in_write", 32'(in_ready), 32'd0);
            end
            if (load_done) done_cnt++;
        end
    end

    logic [7:0] stim[$];

    task automatic build(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(n));
        cs = 8'(n);
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                stim.push_back(b);
                cs ^= b;
            end
            if (corrupt) cs ^= 8'($urandom_range(255, 1));
            stim.push_back(cs);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int duty, input bit poke);
        int idx = 0;
        int guard = 0;
        while (idx < stim.size()) begin
            @(negedge clk);
            in_valid = (int'($urandom_range(99)) < duty);
            in_data  = stim[idx];
            start    = poke && (idx == 3);
            if (in_valid && in_ready) idx++;
            guard++;
            if (guard > 5000) begin
                check("send_timeout", 32'(idx), 32'(stim.size()));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Reference: what the image says should land in memory and how the load ends.
    task automatic run(input int duty, input bit poke, input string name);
        logic [31:0] exp_words[$];
        logic [7:0]  cs;
        int          n;
        bit          cnt_ok;
        bit          ok;
        n      = int'(stim[0]);
        cnt_ok = (n >= 1) && (n <= DEPTH);
        ok     = 1'b0;
        if (cnt_ok) begin
            cs = stim[0];
            for (int w = 0; w < n; w++) begin
                exp_words.push_back({stim[4*w+4], stim[4*w+3], stim[4*w+2], stim[4*w+1]});
                for (int k = 1; k <= 4; k++) cs ^= stim[4*w+k];
            end
            ok = (stim[4*n+1] == cs);
        end
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        pulse_start();
        send(duty, poke);
        if (!cnt_ok) check({name, "_err_after_count"}, 32'(load_err), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_nwrites"}, 32'(wr_data.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wr_data.size(); i++) begin
            check({name, "_addr"}, 32'(wr_addr[i]), 32'(i));
            check({name, "_data"}, wr_data[i], exp_words[i]);
        end
        check({name, "_done"}, 32'(done_cnt), ok ? 32'd1 : 32'd0);
        check({name, "_run"}, 32'(cpu_run), 32'(ok));
        check({name, "_err"}, 32'(load_err), 32'(!ok));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 32'(in_ready), 32'd0);
        check({name, "_we"}, 32'(imem_we), 32'd0);
        check({name, "_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_wdata"}, imem_wdata, 32'd0);
        check({name, "_run"}, 32'(cpu_run), 32'd0);
        check({name, "_done"}, 32'(load_done), 32'd0);
        check({name, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed two-word image with good checksum
        stim = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46};
        run(100, 1'b0, "dir_ok");
        if (wr_data.size() == 2) begin
            check("dir_w0", wr_data[0], 32'h11223344);
            check("dir_w1", wr_data[1], 32'hAABBCCDD);
        end else begin
            check("dir_w_count", 32'(wr_data.size()), 32'd2);
        end

        // Start after success drops cpu_run; abandon via bad count
        pulse_start();
        check("restart_run_drop", 32'(cpu_run), 32'd0);
        stim = '{8'h00};
        send(100, 1'b0);
        repeat (2) @(negedge clk);

        // Same image, wrong checksum
        stim = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h47};
        run(100, 1'b0, "dir_bad");

        // Start clears a sticky error
        pulse_start();
        check("restart_err_clear", 32'(load_err), 32'd0);
        stim = '{8'h00};
        send(100, 1'b0);
        repeat (2) @(negedge clk);

        stim = '{8'h00};
        run(100, 1'b0, "cnt0");
        stim = '{8'h11};
        run(100, 1'b0, "cnt17");

        build(DEPTH, 1'b0);
        run(30, 1'b0, "full30");

        build(3, 1'b0);
        run(100, 1'b1, "poke");

        for (int k = 0; k < 6; k++) begin
            build(int'($urandom_range(DEPTH, 1)), 1'($urandom_range(1)));
            run(int'($urandom_range(100, 40)), k[0], "rnd");
        end

        // Reset in the middle of the second word
        build(2, 1'b0);
        while (stim.size() > 7) void'(stim.pop_back());
        wr_data.delete();
        wr_addr.delete();
        pulse_start();
        send(100, 1'b0);
        check("partial_nwrites", 32'(wr_data.size()), 32'd1);
        if (wr_data.size() > 0)
            check("partial_w0", wr_data[0], {stim[4], stim[3], stim[2], stim[1]});
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        build(1, 1'b0);
        run(100, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: loads a program image into the instruction memory that the processor fetches from.
- Receives a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them to sequential addresses starting at 0.
- Verifies a trailing XOR checksum.
- Holds the processor out of execution (cpu_run low) until a load completes cleanly.

Parameters:
- ADDR_W, 4, instruction memory word-address width; depth DEPTH = 2^ADDR_W (16).
- DATA_W, 32, instruction word width; fixed at 32 (4 bytes per word), other values unsupported.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load; honoured only in IDLE
- in_valid  in  1  byte-stream source has a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid and in_ready are both high at a rising edge
- imem_we  out  1  instruction memory write enable, single-cycle pulse per word
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  write data
- cpu_run  out  1  high means the processor may execute; low means it is held in reset
- load_done  out  1  one-cycle pulse on a successful load
- load_err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset (rst low, asynchronous): state IDLE.
  - in_ready, imem_we, load_done, load_err, cpu_run all 0.
  - imem_addr, imem_wdata, internal count, byte index and checksum all 0.
- Registered outputs: in_ready, imem_we, imem_addr and imem_wdata are registered; no combinational path from input to output.
- States: IDLE, COUNT, BYTES, WRITE, CSUM. Transitions:
- IDLE:
  - start=1 -> COUNT next cycle.
  - Same edge: cpu_run<=0, load_err<=0, checksum<=0, in_ready<=1.
- COUNT:
  - On a handshake, N<=in_data and checksum^=in_data.
  - N==0 or N>DEPTH -> load_err<=1, in_ready<=0, go to IDLE.
  - Otherwise addr<=0, byte_idx<=0, go to BYTES.
- BYTES:
  - Each handshake places in_data at bits [8*byte_idx+7 : 8*byte_idx] of the word, checksum^=in_data, byte_idx++.
  - On the handshake with byte_idx==3: in_ready<=0, go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1 with imem_addr/imem_wdata stable.
  - addr==N-1 -> CSUM.
  - Otherwise addr++ and in_ready<=1 -> BYTES.
  - No byte is accepted in WRITE.
- CSUM (in_ready=1):
  - One handshake compares in_data against the checksum.
  - Match -> cpu_run<=1, load_done=1 for one cycle, go to IDLE.
  - Mismatch -> load_err<=1, cpu_run stays 0, go to IDLE.
  - Either way in_ready<=0.
- Checksum: XOR of the count byte and every data byte.
- Throughput: minimum 5 cycles per word (4 byte cycles + 1 write). The source may stall with in_valid low at any time; the loader state is held.
- start outside IDLE is ignored.
- start while cpu_run=1 starts a reload; cpu_run drops at that edge.
- Words already written before an error stay in memory; only cpu_run gates execution.
- Reset mid-load: immediate return to IDLE, imem_we drops asynchronously, no partial word is written.
- imem_addr wraps never, because N is bounded by DEPTH.

Decomposition:
- Shared package (imem_loader_pkg):
  - state enum: IDLE, COUNT, BYTES, WRITE, CSUM
  - BYTES_PER_WORD=4
  - function computing DEPTH from ADDR_W
- Sub-module byte_packer: 2-bit byte index, 32-bit shift/insert register, clear input, word_full output. This is the natural split; the FSM stays in imem_loader.

Test Plan:
- Reset then start, stream 02 44 33 22 11 DD CC BB AA 46 with in_valid always high.
  - Required: writes addr0=0x11223344, addr1=0xAABBCCDD.
  - load_done pulses once; cpu_run=1; load_err=0.
- Same stream with checksum 0x47.
  - Required: both words written, load_err=1, cpu_run=0, no load_done.
- Count byte 0x00, and separately 0x11 (17 > 16).
  - Required: load_err=1 immediately after the count byte; no imem_we ever.
- N=16 with a random in_valid duty of 30%.
  - Required: 16 writes to addr 0..15 with correct words.
  - in_ready stays low during each WRITE cycle; no byte is lost or duplicated.
- Assert rst low after the 6th data byte, release, then perform a clean N=1 load.
  - Required: all outputs at reset values immediately; subsequent load correct.
- start pulses during BYTES are ignored.
  - start after success drops cpu_run at the next edge and clears load_err.
